alu_exec_stage: RTL
===================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  instruction offered this cycle.
REQ-004 in_ready  output  1  stage accepts; transfer when in_valid && in_ready at posedge clk.
REQ-005 in_op  input  3  ALU opcode (REQ-013).
REQ-006 in_rd / in_rs1 / in_rs2  input  4 each  destination / source register indices.
REQ-007 raddr1 / raddr2  output  4 each  register-file read addresses; combinational copies of in_rs1 / in_rs2.
REQ-008 rdata1 / rdata2  input  16 each  register-file read data; combinational response to raddr1/raddr2.
REQ-009 we / waddr / wdata  output  1 / 4 / 16  register-file write port; all three driven directly from flops.
REQ-010 flag_zero / flag_carry  output  1 each  flags of the result currently on wdata.

Function
REQ-011 Two stages: EX register (ex_valid, op, rd, A, B) loaded on accept; WB register (we, waddr, wdata, flags) loaded from EX each cycle.
REQ-012 Latency: accept at edge N -> we=1 with result during the cycle after edge N+1 -> register file updated at edge N+2; throughput one per cycle when not stalled.
REQ-013 Opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[3:0], 110 SHR logical A by B[3:0], 111 MOV (result=A).
REQ-014 Result truncated to 16 bits; wrap-around, no saturation.
REQ-015 flag_carry: ADD = bit 16 of 17-bit sum; SUB = 1 when A<B unsigned (borrow); all other ops 0.
REQ-016 flag_zero = (result == 16'h0000) for every op.
REQ-017 When ex_valid=0 at an edge, WB loads we=0; waddr, wdata and flags hold their previous values.
REQ-018 Hazard: EX hazard when ex_valid && ex_rd matches in_rs1 or in_rs2; WB hazard when we && waddr matches in_rs1 or in_rs2.
REQ-019 Hazards are evaluated only when in_valid=1; in_ready is independent of in_valid otherwise.
REQ-020 Simultaneous EX and WB hazard on the same source: the EX (younger) value has priority.
REQ-021 in_rs1 == in_rs2 is legal; both operands resolved identically.
REQ-022 in_rd equal to a source of the same instruction is legal; operands are the values before this write.
REQ-023 No downstream backpressure: WB always retires in one cycle.

Reset
REQ-024 rst_n=0 asynchronously clears ex_valid, we, waddr, wdata, flag_zero, flag_carry to 0, and EX operand/op/rd fields to 0.
REQ-025 in_ready = 1 while rst_n=0 and on the first cycle after release.
REQ-026 Instructions in flight at reset assertion are discarded; no write is issued for them.

Configuration
REQ-027 Macro ALU_BYPASS_EN defined: operands forwarded -- EX hazard takes the combinational ALU result of the EX stage, WB hazard takes wdata, otherwise rdata; in_ready is constant 1 outside reset.
REQ-028 ALU_BYPASS_EN undefined: no forwarding; in_ready = 0 while any hazard (REQ-018) exists, operands always from rdata1/rdata2; stall lasts at most two cycles.
REQ-029 Results, flags and write ordering are identical in both builds; only cycle timing differs.

Verification
REQ-030 Reset, regfile R1=0x0005, R2=0x0003: ADD rd=3 rs1=1 rs2=2 -> we=1, waddr=3, wdata=0x0008, carry=0, zero=0 two edges after accept.
REQ-031 R1=0xFFFF, R2=0x0001: ADD rd=4 -> wdata=0x0000, carry=1, zero=1; SUB rd=5 rs1=2 rs2=1 -> wdata=0x0002, carry=1.
REQ-032 Back-to-back ADD rd=3 (R1+R2=8) then ADD rd=6 rs1=3 rs2=3 -> wdata=0x0010; bypass build: no in_ready drop; non-bypass build: in_ready=0 for exactly 2 cycles.
REQ-033 Same-source priority: MOV rd=7 rs1=1, MOV rd=7 rs1=2, then ADD rd=8 rs1=7 rs2=7 -> uses R2 value (0x0003+0x0003=0x0006).
REQ-034 SHL A=0x8001 by B=1 -> 0x0002, carry=0; SHR by 15 -> 0x0001; in_valid=0 gap cycle -> we=0, wdata held.
REQ-035 rst_n pulsed low while an instruction is in EX -> we stays 0, no write to regfile, in_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage (EX -> WB) 16-bit ALU pipeline with a 16-entry
// register-file read/write interface and RAW hazard handling.
// Build option: define ALU_BYPASS_EN to forward operands from the EX ALU output
// and from the WB register. In that build in_ready stays 1. Without the macro,
// in_ready drops while a hazard exists and operands always come from rdata1/rdata2.
`timescale 1ns/1ps

module alu_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  output logic [3:0]  raddr1,
  output logic [3:0]  raddr2,
  input  logic [15:0] rdata1,
  input  logic [15:0] rdata2,
  output logic        we,
  output logic [3:0]  waddr,
  output logic [15:0] wdata,
  output logic        flag_zero,
  output logic        flag_carry
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MOV = 3'b111
  } alu_op_e;

  // EX stage register
  logic        ex_valid_q, ex_valid_d;
  alu_op_e     ex_op_q,    ex_op_d;
  logic [3:0]  ex_rd_q,    ex_rd_d;
  logic [15:0] ex_a_q,     ex_a_d;
  logic [15:0] ex_b_q,     ex_b_d;

  // WB stage register
  logic        we_q,    we_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        zero_q,  zero_d;
  logic        carry_q, carry_d;

  // ALU outputs for the instruction currently in EX
  logic [15:0] ex_res;
  logic        ex_carry;
  logic        ex_zero;

  // Hazard detection and operand selection
  logic        ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic [15:0] opnd_a, opnd_b;
  logic        accept;

  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  // ALU on the EX operands; carry is the add carry-out or subtract borrow
  always_comb begin
    ex_res   = '0;
    ex_carry = 1'b0;
    case (ex_op_q)
      OP_ADD:  {ex_carry, ex_res} = {1'b0, ex_a_q} + {1'b0, ex_b_q};
      OP_SUB: begin
        ex_res   = ex_a_q - ex_b_q;
        ex_carry = (ex_a_q < ex_b_q);
      end
      OP_AND:  ex_res = ex_a_q & ex_b_q;
      OP_OR:   ex_res = ex_a_q | ex_b_q;
      OP_XOR:  ex_res = ex_a_q ^ ex_b_q;
      OP_SHL:  ex_res = ex_a_q << ex_b_q[3:0];
      OP_SHR:  ex_res = ex_a_q >> ex_b_q[3:0];
      OP_MOV:  ex_res = ex_a_q;
      default: ex_res = ex_a_q;
    endcase
    ex_zero = (ex_res == '0);
  end

  // Source matches against the EX and WB destinations
  always_comb begin
    ex_hit1 = ex_valid_q && (ex_rd_q == in_rs1);
    ex_hit2 = ex_valid_q && (ex_rd_q == in_rs2);
    wb_hit1 = we_q && (waddr_q == in_rs1);
    wb_hit2 = we_q && (waddr_q == in_rs2);
  end

`ifdef ALU_BYPASS_EN
  // Forward the youngest in-flight value; EX wins over WB on the same source
  always_comb begin
    opnd_a   = ex_hit1 ? ex_res : (wb_hit1 ? wdata_q : rdata1);
    opnd_b   = ex_hit2 ? ex_res : (wb_hit2 ? wdata_q : rdata2);
    in_ready = 1'b1;
  end
`else
  // Stall while any source is still in flight; a stall clears within two cycles
  always_comb begin
    opnd_a   = rdata1;
    opnd_b   = rdata2;
    in_ready = !(in_valid && (ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2));
  end
`endif

  assign accept = in_valid && in_ready;

  // EX next state: capture on accept, otherwise bubble with fields held
  always_comb begin
    ex_valid_d = accept;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (accept) begin
      ex_op_d = alu_op_e'(in_op);
      ex_rd_d = in_rd;
      ex_a_d  = opnd_a;
      ex_b_d  = opnd_b;
    end
  end

  // WB next state: retire EX every cycle; a bubble drops we and holds the rest
  always_comb begin
    we_d    = ex_valid_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    if (ex_valid_q) begin
      waddr_d = ex_rd_q;
      wdata_d = ex_res;
      zero_d  = ex_zero;
      carry_d = ex_carry;
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= OP_ADD;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

endmodule
